// File: rtl/game_flow_controller_if.sv
// Purpose: groups the controller's input events, per-screen pixel sources and
//          status/pixel outputs into one bundle between the screen renderers,
//          the OLED driver and game_flow_controller.
// Ports:   master = controller side (drives status + oled_data),
//          slave  = surrounding system side (drives button, guess, pixel sources).
interface game_flow_controller_if;
  logic        btnC;
  logic        guess_correct;
  logic [15:0] oled_menu;
  logic [15:0] oled_count;
  logic [15:0] oled_draw;
  logic [15:0] oled_result;
  logic [15:0] oled_data;
  logic [1:0]  screen;
  logic        game_start;
  logic        round_active;
  logic [2:0]  round_num;
  logic [2:0]  score;
  logic [5:0]  secs_left;

  modport master (
    input  btnC, guess_correct, oled_menu, oled_count, oled_draw, oled_result,
    output oled_data, screen, game_start, round_active, round_num, score, secs_left
  );

  modport slave (
    output btnC, guess_correct, oled_menu, oled_count, oled_draw, oled_result,
    input  oled_data, screen, game_start, round_active, round_num, score, secs_left
  );
endinterface

// File: rtl/game_flow_controller.sv
// Purpose: Skribble screen sequencer. Debounces btnC, runs MENU -> COUNTDOWN ->
//          DRAW rounds -> RESULT, tracks round/score/seconds, and muxes the
//          per-screen RGB565 pixel sources onto one registered OLED bus.
// Latency: every state/status update and oled_data take exactly one clk edge.
// Flow:    no backpressure; pixel sources are sampled every cycle.
// Ports:   clk, reset (synchronous, active-low), bus (game_flow_controller_if.master):
//          in  btnC (raw, async), guess_correct (pulse), oled_menu/count/draw/result
//          out oled_data, screen, game_start, round_active, round_num, score, secs_left
// Option:  define RESULT_AUTO_RETURN_EN to make RESULT count RESULT_SEC down and
//          fall back to MENU on its own (press still returns early).
module game_flow_controller #(
  parameter int TICK_DIV        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int COUNTDOWN_SEC   = 3,
  parameter int DRAW_SEC        = 60,
  parameter int NUM_ROUNDS      = 3,
  parameter int RESULT_SEC      = 10
) (
  input logic                   clk,
  input logic                   reset,
  game_flow_controller_if.master bus
);

  typedef enum logic [1:0] {
    S_MENU   = 2'd0,
    S_COUNT  = 2'd1,
    S_DRAW   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef RESULT_AUTO_RETURN_EN
  localparam bit AUTO_RETURN = 1'b1;
`else
  localparam bit AUTO_RETURN = 1'b0;
`endif

  localparam logic [5:0] RESULT_LOAD = AUTO_RETURN ? 6'(RESULT_SEC) : 6'd0;

  state_t              state;
  state_t              state_nxt;
  logic [5:0]          secs_left;
  logic [5:0]          secs_nxt;
  logic [2:0]          round_num;
  logic [2:0]          round_nxt;
  logic [2:0]          score;
  logic [2:0]          score_nxt;
  logic                game_start;
  logic                start_nxt;
  logic [15:0]         oled_data;

  logic                btn_meta;
  logic                btn_sync;
  logic                btn_deb;
  logic [DB_W-1:0]     db_cnt;
  logic                db_flip;
  logic                armed;
  logic                press;

  logic [TICK_W-1:0]   tick_cnt;
  logic                sec_tick;
  logic                expire;

  // ---------------------------------------------------------------------------
  // Button: 2-flop synchroniser (no reset, it only samples the pad), then a
  // counter that flips the debounced level after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    btn_meta <= bus.btnC;
    btn_sync <= btn_meta;
  end

  assign db_flip = (btn_sync != btn_deb) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

  // Press fires on the same edge the debounced level rises.
  assign press = db_flip && btn_sync && armed;

  always_ff @(posedge clk) begin
    if (!reset) begin
      db_cnt  <= '0;
      btn_deb <= 1'b0;
      armed   <= 1'b0;
    end else begin
      if (btn_sync == btn_deb) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        db_cnt  <= '0;
        btn_deb <= btn_sync;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      // The debounced level is cleared by reset, so also require the synced
      // pad to read released; otherwise a button held through reset would
      // produce a press as soon as it debounced high.
      if (!btn_deb && !btn_sync) begin
        armed <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Seconds tick: restarts on every state change so each screen gets whole
  // seconds from its entry edge.
  // ---------------------------------------------------------------------------
  assign sec_tick = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign expire   = sec_tick && (secs_left == 6'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if ((state_nxt != state) || sec_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Screen FSM: next state and next status values.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    secs_nxt  = secs_left;
    round_nxt = round_num;
    score_nxt = score;
    start_nxt = 1'b0;

    case (state)
      S_MENU: begin
        if (press) begin
          state_nxt = S_COUNT;
          start_nxt = 1'b1;
          round_nxt = 3'd1;
          score_nxt = 3'd0;
          secs_nxt  = 6'(COUNTDOWN_SEC);
        end
      end

      S_COUNT: begin
        if (expire) begin
          state_nxt = S_DRAW;
          secs_nxt  = 6'(DRAW_SEC);
        end else if (sec_tick && (secs_left > 6'd1)) begin
          secs_nxt = secs_left - 6'd1;
        end
      end

      S_DRAW: begin
        // A guess landing on the expiry cycle still counts as correct.
        if (bus.guess_correct || expire) begin
          if (bus.guess_correct && (score < 3'(NUM_ROUNDS))) begin
            score_nxt = score + 3'd1;
          end
          if (round_num >= 3'(NUM_ROUNDS)) begin
            state_nxt = S_RESULT;
            secs_nxt  = RESULT_LOAD;
          end else begin
            state_nxt = S_COUNT;
            round_nxt = round_num + 3'd1;
            secs_nxt  = 6'(COUNTDOWN_SEC);
          end
        end else if (sec_tick && (secs_left > 6'd1)) begin
          secs_nxt = secs_left - 6'd1;
        end
      end

      S_RESULT: begin
`ifdef RESULT_AUTO_RETURN_EN
        if (press || expire) begin
          state_nxt = S_MENU;
          round_nxt = 3'd0;
          secs_nxt  = 6'd0;
        end else if (sec_tick && (secs_left > 6'd1)) begin
          secs_nxt = secs_left - 6'd1;
        end
`else
        if (press) begin
          state_nxt = S_MENU;
          round_nxt = 3'd0;
          secs_nxt  = 6'd0;
        end
`endif
      end

      default: begin
        state_nxt = S_MENU;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_MENU;
      secs_left  <= 6'd0;
      round_num  <= 3'd0;
      score      <= 3'd0;
      game_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      secs_left  <= secs_nxt;
      round_num  <= round_nxt;
      score      <= score_nxt;
      game_start <= start_nxt;
    end
  end

  // Pixel mux keyed on the state being entered so the bus switches source on
  // the same edge as the screen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      oled_data <= 16'd0;
    end else begin
      case (state_nxt)
        S_MENU:   oled_data <= bus.oled_menu;
        S_COUNT:  oled_data <= bus.oled_count;
        S_DRAW:   oled_data <= bus.oled_draw;
        S_RESULT: oled_data <= bus.oled_result;
        default:  oled_data <= bus.oled_menu;
      endcase
    end
  end

  assign bus.oled_data    = oled_data;
  assign bus.screen       = state;
  assign bus.game_start   = game_start;
  assign bus.round_active = (state == S_DRAW);
  assign bus.round_num    = round_num;
  assign bus.score        = score;
  assign bus.secs_left    = secs_left;

endmodule
